// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables, rotation schedule, widths, FSM states.
// Right-rotate helper only exists when DES_KEYSCHED_DECRYPT_EN is defined.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;
  localparam int ROUND_W  = 4;

  // Entries are FIPS bit numbers, 1 = most significant bit of the source vector.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] h, input logic [1:0] n);
    return (n == 2'd2) ? {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]}
                       : {h[HALF_W-2:0], h[HALF_W-1]};
  endfunction

`ifdef DES_KEYSCHED_DECRYPT_EN
  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] h, input logic [1:0] n);
    return (n == 2'd2) ? {h[1:0], h[HALF_W-1:2]}
                       : {h[0], h[HALF_W-1:1]};
  endfunction
`endif

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: pure wiring from the 56-bit {C,D} register pair to a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*HALF_W-1:0] cd,
  output logic [SUBKEY_W-1:0] subkey
);

  for (genvar j = 0; j < SUBKEY_W; j++) begin : g_sel
    assign subkey[SUBKEY_W-1-j] = cd[2*HALF_W-PC2[j]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: PC-1 on load, one C/D rotation per advance, PC-2 output.
// Define DES_KEYSCHED_DECRYPT_EN to add the decrypt port and K16..K1 ordering.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                key_load,
`ifdef DES_KEYSCHED_DECRYPT_EN
  input  logic                decrypt,
`endif
  input  logic                advance,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  output logic [ROUND_W-1:0]  round,
  output logic                done
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  state_t              state;
  logic [HALF_W-1:0]   c;
  logic [HALF_W-1:0]   d;
  logic [HALF_W-1:0]   load_c;
  logic [HALF_W-1:0]   load_d;
  logic [HALF_W-1:0]   step_c;
  logic [HALF_W-1:0]   step_d;
  logic [2*HALF_W-1:0] pc1_cd;
  logic [ROUND_W-1:0]  enc_idx;
  logic [1:0]          enc_shift;
  logic                parity_unused;

  for (genvar j = 0; j < 2*HALF_W; j++) begin : g_pc1
    assign pc1_cd[2*HALF_W-1-j] = key_in[KEY_W-PC1[j]];
  end

  // The eight DES parity bits never reach PC-1.
  assign parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  assign enc_idx   = round + ROUND_W'(1);
  assign enc_shift = SHIFT_SCHED[enc_idx];

`ifdef DES_KEYSCHED_DECRYPT_EN
  logic       mode;
  logic [1:0] dec_shift;

  assign dec_shift = SHIFT_SCHED[ROUND_W'(15) - round];

  // Decrypt loads PC-1 unrotated: the full 28-bit rotation is the identity, i.e. K16.
  always_comb begin
    load_c = pc1_cd[2*HALF_W-1:HALF_W];
    load_d = pc1_cd[HALF_W-1:0];
    if (!decrypt) begin
      load_c = rotl(pc1_cd[2*HALF_W-1:HALF_W], SHIFT_SCHED[0]);
      load_d = rotl(pc1_cd[HALF_W-1:0], SHIFT_SCHED[0]);
    end
    step_c = mode ? rotr(c, dec_shift) : rotl(c, enc_shift);
    step_d = mode ? rotr(d, dec_shift) : rotl(d, enc_shift);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= 1'b0;
    end else if (key_load) begin
      mode <= decrypt;
    end
  end
`else
  always_comb begin
    load_c = rotl(pc1_cd[2*HALF_W-1:HALF_W], SHIFT_SCHED[0]);
    load_d = rotl(pc1_cd[HALF_W-1:0], SHIFT_SCHED[0]);
    step_c = rotl(c, enc_shift);
    step_d = rotl(d, enc_shift);
  end
`endif

  // key_load outranks advance; the final advance leaves C, D and round untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      round <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (key_load) begin
        c     <= load_c;
        d     <= load_d;
        round <= '0;
        state <= RUN;
      end else if (state == RUN && advance) begin
        if (round == LAST_ROUND) begin
          state <= IDLE;
          done  <= 1'b1;
        end else begin
          c     <= step_c;
          d     <= step_d;
          round <= round + ROUND_W'(1);
        end
      end
    end
  end

  assign subkey_valid = (state == RUN);

  des_pc2 u_pc2 (
    .cd     ({c, d}),
    .subkey (subkey)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed self-checking bench for des_key_schedule against the classic FIPS example subkeys.
// Decrypt ordering is exercised only when DES_KEYSCHED_DECRYPT_EN is defined.
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic [63:0] key_in;
  logic        key_load;
  logic        decrypt;
  logic        advance;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        done;

  int tests;
  int fails;
  int exp_round;
  logic adv;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [47:0] KEY_B_K1 = 48'h36146478E1E1;

  logic [47:0] gold [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_load     (key_load),
`ifdef DES_KEYSCHED_DECRYPT_EN
    .decrypt      (decrypt),
`endif
    .advance      (advance),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ld, input logic adv_in, input logic [63:0] k);
    key_load = ld;
    advance  = adv_in;
    key_in   = k;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [47:0] k, input int r,
                            input logic v, input logic dn);
    checkOutput({tag, " subkey"}, 64'(subkey), 64'(k));
    checkOutput({tag, " round"}, 64'(round), 64'(r));
    checkOutput({tag, " valid"}, 64'(subkey_valid), 64'(v));
    checkOutput({tag, " done"}, 64'(done), 64'(dn));
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    key_load = 1'b0;
    advance  = 1'b0;
    decrypt  = 1'b0;
    key_in   = '0;

    applyStimulus(1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkState("reset", 48'h0, 0, 1'b0, 1'b0);
    rst = 1'b0;

    // Advance in IDLE must do nothing.
    applyStimulus(1'b0, 1'b1, KEY_A);
    checkState("idle_adv", 48'h0, 0, 1'b0, 1'b0);

    // Full encrypt schedule with advance held high.
    applyStimulus(1'b1, 1'b0, KEY_A);
    checkState("load_k1", gold[0], 0, 1'b1, 1'b0);
    for (int r = 1; r < 16; r++) begin
      applyStimulus(1'b0, 1'b1, KEY_A);
      checkState($sformatf("seq_k%0d", r + 1), gold[r], r, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, KEY_A);
    checkState("final_done", gold[15], 15, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, KEY_A);
    checkState("done_pulse_end", gold[15], 15, 1'b0, 1'b0);

    // Random stalls: subkey must track the round count and hold while advance is low.
    applyStimulus(1'b1, 1'b0, KEY_A);
    exp_round = 0;
    checkState("stall_load", gold[0], 0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      adv = (exp_round < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(1'b0, adv, KEY_A);
      if (adv) exp_round++;
      checkState($sformatf("stall_%0d", i), gold[exp_round], exp_round, 1'b1, 1'b0);
    end
    for (int i = 0; i < 16 && exp_round < 15; i++) begin
      applyStimulus(1'b0, 1'b1, KEY_A);
      exp_round++;
      checkState($sformatf("stall_tail_%0d", i), gold[exp_round], exp_round, 1'b1, 1'b0);
    end

    // Reload mid-sequence at round 7, coinciding with an advance.
    applyStimulus(1'b1, 1'b0, KEY_A);
    for (int r = 1; r <= 7; r++) applyStimulus(1'b0, 1'b1, KEY_A);
    checkState("pre_reload", gold[7], 7, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, KEY_B);
    checkState("reload_b_k1", KEY_B_K1, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, KEY_B);
    checkState("reload_hold", KEY_B_K1, 0, 1'b1, 1'b0);

    // Load in the same cycle as the final advance wins and suppresses done.
    applyStimulus(1'b1, 1'b0, KEY_A);
    for (int r = 1; r <= 15; r++) applyStimulus(1'b0, 1'b1, KEY_A);
    checkState("pre_final_load", gold[15], 15, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, KEY_A);
    checkState("final_load_wins", gold[0], 0, 1'b1, 1'b0);

    // Synchronous reset at round 5.
    for (int r = 1; r <= 5; r++) applyStimulus(1'b0, 1'b1, KEY_A);
    checkState("pre_reset", gold[5], 5, 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, KEY_A);
    checkState("mid_reset", 48'h0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, KEY_A);
    checkState("post_reset_adv", 48'h0, 0, 1'b0, 1'b0);

`ifdef DES_KEYSCHED_DECRYPT_EN
    // Decrypt ordering K16..K1, round still counting up.
    decrypt = 1'b1;
    applyStimulus(1'b1, 1'b0, KEY_A);
    decrypt = 1'b0;
    checkState("dec_k16", gold[15], 0, 1'b1, 1'b0);
    for (int r = 1; r < 16; r++) begin
      applyStimulus(1'b0, 1'b1, KEY_A);
      checkState($sformatf("dec_r%0d", r), gold[15 - r], r, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, KEY_A);
    checkState("dec_done", gold[0], 15, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, KEY_A);
    checkState("enc_after_dec", gold[0], 0, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
